// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier side unit for the LEGv8 MUL / W-form multiply.
// Optional build macro MUL_SEQ_EARLY_EXIT_EN ends the RUN phase once the multiplier is exhausted.
module mul_sequencer #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              sf,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int HALF_W = DATA_W / 2;
  localparam logic [DATA_W-1:0] LO_MASK = {{(DATA_W-HALF_W){1'b0}}, {HALF_W{1'b1}}};
  localparam logic [CNT_W-1:0]  N_FULL  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  N_HALF  = CNT_W'(HALF_W);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              sf_q, sf_d;
  logic              accept;
  logic              run_end;

  assign accept = (state_q == IDLE) && start && !flush;

  // RUN always performs at least one iteration; the exit cycle itself does no arithmetic.
`ifdef MUL_SEQ_EARLY_EXIT_EN
  assign run_end = (count_q == '0) ||
                   ((mplier_q == '0) && (count_q != (sf_q ? N_FULL : N_HALF)));
`else
  assign run_end = (count_q == '0);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN: begin
        if (flush)        state_d = IDLE;
        else if (run_end) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN) || (state_q == DONE);
    done = (state_q == DONE);
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    sf_d     = sf_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mcand_d  = sf ? op_a : (op_a & LO_MASK);
          mplier_d = sf ? op_b : (op_b & LO_MASK);
          acc_d    = '0;
          count_d  = sf ? N_FULL : N_HALF;
          sf_d     = sf;
        end
      end
      RUN: begin
        if (!flush) begin
          if (run_end) begin
            result_d = sf_q ? acc_q : (acc_q & LO_MASK);
          end else begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q - CNT_ONE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      sf_q     <= 1'b0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      sf_q     <= sf_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: product and latency come from an arithmetic reference model.
module tb_mul_sequencer;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 7;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              sf    = 1'b0;
  logic              flush = 1'b0;
  logic [DATA_W-1:0] op_a  = '0;
  logic [DATA_W-1:0] op_b  = '0;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;

  int checks = 0;
  int errors = 0;

  mul_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .sf    (sf),
    .op_a  (op_a),
    .op_b  (op_b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clock = ~clock;

  // Reference: low word of the product of the (width-reduced) operands.
  function automatic logic [63:0] model_result(input logic [63:0] a, input logic [63:0] b,
                                               input logic s);
    logic [127:0] p;
    if (s) p = {64'h0, a} * {64'h0, b};
    else   p = {96'h0, a[31:0]} * {96'h0, b[31:0]};
    return s ? p[63:0] : {32'h0, p[31:0]};
  endfunction

  // Reference: number of edges after the start-sampling edge until done is visible.
  function automatic int model_latency(input logic [63:0] b, input logic s);
    int runs;
`ifdef MUL_SEQ_EARLY_EXIT_EN
    runs = 1;
    for (int i = 0; i < (s ? 64 : 32); i++) if (b[i]) runs = i + 1;
`else
    runs = b[0] ? (s ? 64 : 32) : (s ? 64 : 32);
`endif
    return runs + 1;
  endfunction

  // Drives one request and measures; called #1 after an edge, returns #1 after the edge following done.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                       output int lat, output logic [63:0] res, output logic busy1,
                       output logic busy_after, output logic done_after);
    op_a = a; op_b = b; sf = s; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    busy1 = busy;
    lat = 0;
    res = '0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clock); #1;
      if (done) begin
        lat = k;
        res = result;
        break;
      end
    end
    @(posedge clock); #1;
    busy_after = busy;
    done_after = done;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    start = 1'b1; op_a = 64'd9; op_b = 64'd9; sf = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_held_busy: got %b expected 0", busy); end
    start = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_op(input string name, input logic [63:0] a, input logic [63:0] b,
                         input logic s);
    int lat; logic [63:0] res; logic b1, ba, da;
    do_op(a, b, s, lat, res, b1, ba, da);
    checks++; if (lat !== model_latency(b, s)) begin errors++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, model_latency(b, s)); end
    checks++; if (res !== model_result(a, b, s)) begin errors++;
      $display("FAIL %s_result: got %h expected %h", name, res, model_result(a, b, s)); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL %s_busy_start: got %b expected 1", name, b1); end
    checks++; if ({ba, da} !== 2'b00) begin errors++;
      $display("FAIL %s_after_done: got busy=%b done=%b expected 0 0", name, ba, da); end
  endtask

  task automatic test_full();
    test_op("full", 64'd3, 64'd5, 1'b1);
    checks++; if (result !== 64'd15) begin errors++; $display("FAIL full_15: got %0d expected 15", result); end
  endtask

  task automatic test_wform();
    test_op("wform", 64'h0000_0001_0000_0003, 64'hFFFF_FFFF_0000_0002, 1'b0);
    checks++; if (result !== 64'd6) begin errors++; $display("FAIL wform_6: got %h expected 6", result); end
  endtask

  task automatic test_wrap();
    test_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1);
    checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++;
      $display("FAIL wrap_value: got %h expected fffffffffffffffe", result); end
  endtask

  task automatic test_early_exit();
    test_op("mul7x4", 64'd7, 64'd4, 1'b1);
    checks++; if (result !== 64'd28) begin errors++; $display("FAIL mul7x4_28: got %0d expected 28", result); end
    test_op("mulx0", 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b1);
    test_op("wform_top", 64'h0000_0000_8000_0001, 64'h0000_0000_8000_0000, 1'b0);
  endtask

  task automatic test_ignored_start();
    int lat; logic [63:0] res;
    lat = 0; res = '0;
    op_a = 64'd6; op_b = 64'h8000_0000_0000_0007; sf = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clock); #1;
      if (k == 5) begin op_a = 64'd100; op_b = 64'd100; start = 1'b1; end
      if (k == 6) start = 1'b0;
      if (done) begin lat = k; res = result; break; end
    end
    checks++; if (lat !== model_latency(64'h8000_0000_0000_0007, 1'b1)) begin errors++;
      $display("FAIL ignored_start_latency: got %0d expected %0d", lat,
               model_latency(64'h8000_0000_0000_0007, 1'b1)); end
    checks++; if (res !== model_result(64'd6, 64'h8000_0000_0000_0007, 1'b1)) begin errors++;
      $display("FAIL ignored_start_result: got %h expected %h", res,
               model_result(64'd6, 64'h8000_0000_0000_0007, 1'b1)); end
    @(posedge clock); #1;
  endtask

  task automatic test_flush();
    logic seen_done;
    test_op("preflush", 64'd3, 64'd5, 1'b1);
    seen_done = 1'b0;
    op_a = 64'd9; op_b = 64'hFFFF_FFFF_FFFF_FFFF; sf = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clock); #1;
      if (done) seen_done = 1'b1;
      if (k == 10) flush = 1'b1;
    end
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
    checks++; if (result !== 64'd15) begin errors++; $display("FAIL flush_result: got %0d expected 15", result); end
    for (int k = 0; k < 80; k++) begin
      @(posedge clock); #1;
      if (done || busy) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin errors++;
      $display("FAIL flush_no_done: got activity=%b expected 0", seen_done); end
  endtask

  task automatic test_idle_start_flush();
    logic seen_busy;
    seen_busy = 1'b0;
    op_a = 64'd2; op_b = 64'd2; sf = 1'b1; start = 1'b1; flush = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (busy) seen_busy = 1'b1;
      @(posedge clock); #1;
    end
    checks++; if (seen_busy !== 1'b0) begin errors++;
      $display("FAIL idle_flush_drop: got busy=%b expected 0", seen_busy); end
  endtask

  task automatic test_reset_mid_run();
    op_a = 64'd11; op_b = 64'hFFFF_FFFF_FFFF_FFFF; sf = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (20) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++;
      $display("FAIL midrun_reset_ctrl: got busy=%b done=%b expected 0 0", busy, done); end
    checks++; if (result !== 64'h0) begin errors++;
      $display("FAIL midrun_reset_result: got %h expected 0", result); end
    #1 reset = 1'b1;
    @(posedge clock); #1;
    test_op("after_reset", 64'd3, 64'd5, 1'b1);
  endtask

  task automatic test_back_to_back();
    test_op("b2b_first", 64'd123456789, 64'd987654321, 1'b1);
    test_op("b2b_second", 64'hDEAD_BEEF_0000_0011, 64'hCAFE_F00D_0000_0013, 1'b0);
  endtask

  task automatic test_random();
    logic [63:0] a, b; logic s;
    for (int i = 0; i < 10; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(63, 0);
      s = 1'($urandom_range(1, 0));
      test_op($sformatf("rand%0d", i), a, b, s);
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_wform();
    test_wrap();
    test_early_exit();
    test_ignored_start();
    test_flush();
    test_idle_start_flush();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
